// File: rtl/fu_writeback_arbiter_if.sv
// ============================================================================
// fu_writeback_arbiter_if : FU result inputs and commit-bus outputs of the
//                           writeback arbiter. Revision 1.0
// ============================================================================
`default_nettype none

interface fu_writeback_arbiter_if #(
  parameter int NUM_FU    = 6,
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 96
);
  logic [NUM_FU-1:0]           fu_valid;
  logic [NUM_FU-1:0]           fu_ready;
  logic [NUM_FU*DATA_W-1:0]    fu_data;
  logic                        commit_stall;
  logic [NUM_PORTS-1:0]        commit_valid;
  logic [NUM_PORTS*DATA_W-1:0] commit_data;
  logic [NUM_PORTS*3-1:0]      commit_src;

  modport master (
    input  fu_valid, fu_data, commit_stall,
    output fu_ready, commit_valid, commit_data, commit_src
  );

  modport slave (
    output fu_valid, fu_data, commit_stall,
    input  fu_ready, commit_valid, commit_data, commit_src
  );
endinterface

`default_nettype wire

// File: rtl/fu_writeback_arbiter.sv
// ============================================================================
// fu_writeback_arbiter : per-FU FIFOs feeding NUM_PORTS commit buses with
//                        round-robin grants. Optional starvation counters
//                        under macro WB_ARB_PERF_EN. Revision 1.0
// ============================================================================
`default_nettype none

module fu_writeback_arbiter #(
  parameter int NUM_FU     = 6,
  parameter int NUM_PORTS  = 2,
  parameter int DATA_W     = 96,
  parameter int FIFO_DEPTH = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              flush,
  fu_writeback_arbiter_if.master bus,
  input  wire logic [2:0]        perf_sel,
  output logic [15:0]            perf_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = $clog2(NUM_FU);

  logic [DATA_W-1:0] r_mem    [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr [NUM_FU];
  logic [PTR_W-1:0]  r_wr_ptr [NUM_FU];
  logic [CNT_W-1:0]  r_cnt    [NUM_FU];
  logic [RR_W-1:0]   r_rr_ptr;

  logic [DATA_W-1:0] w_head [NUM_FU];
  logic [NUM_FU-1:0] w_nonempty;
  logic [NUM_FU-1:0] w_full;
  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_pop;
  logic [NUM_FU-1:0] w_grant;
  logic [RR_W-1:0]   w_last;
  logic [RR_W-1:0]   w_rr_next;

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
      assign w_head[gi]     = r_mem[gi][r_rd_ptr[gi]];
      assign w_nonempty[gi] = (r_cnt[gi] != '0);
      assign w_full[gi]     = (r_cnt[gi] == CNT_W'(FIFO_DEPTH));
    end
  endgenerate

  // Ready comes from the registered count alone, so a full FIFO stays
  // not-ready even in the cycle it pops.
  assign bus.fu_ready = ~w_full;
  assign w_push       = bus.fu_valid & ~w_full;
  assign w_pop        = w_grant & {NUM_FU{~bus.commit_stall}};

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (reset || flush) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end else begin
        if (w_push[i]) begin
          r_mem[i][r_wr_ptr[i]] <= bus.fu_data[i*DATA_W +: DATA_W];
          r_wr_ptr[i]           <= r_wr_ptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // Scan FUs circularly from r_rr_ptr; the n-th non-empty FIFO found drives port n.
  always_comb begin
    logic [RR_W:0]   v_sum;
    logic [RR_W-1:0] v_idx;
    int              v_found;
    v_sum            = '0;
    v_idx            = '0;
    v_found          = 0;
    w_grant          = '0;
    w_last           = '0;
    bus.commit_valid = '0;
    bus.commit_data  = '0;
    bus.commit_src   = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      v_sum = {1'b0, r_rr_ptr} + (RR_W+1)'(j);
      if (v_sum >= (RR_W+1)'(NUM_FU)) begin
        v_sum = v_sum - (RR_W+1)'(NUM_FU);
      end
      v_idx = v_sum[RR_W-1:0];
      if (w_nonempty[v_idx]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (v_found == k) begin
            bus.commit_valid[k]                 = 1'b1;
            bus.commit_data[k*DATA_W +: DATA_W] = w_head[v_idx];
            bus.commit_src[k*3 +: 3]            = 3'(v_idx);
            w_grant[v_idx]                      = 1'b1;
            w_last                              = v_idx;
          end
        end
        v_found = v_found + 1;
      end
    end
  end

  assign w_rr_next = (w_last == RR_W'(NUM_FU - 1)) ? '0 : w_last + 1'b1;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rr_ptr <= '0;
    end else if ((|w_grant) && !bus.commit_stall) begin
      r_rr_ptr <= w_rr_next;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [15:0] r_perf [NUM_FU];

  // Starvation: result waiting, commit side open, but another FU took the slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (reset) begin
        r_perf[i] <= '0;
      end else if (w_nonempty[i] && !bus.commit_stall && !w_grant[i] &&
                   (r_perf[i] != 16'hFFFF)) begin
        r_perf[i] <= r_perf[i] + 16'd1;
      end
    end
  end

  always_comb begin
    perf_cnt = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (perf_sel == 3'(i)) begin
        perf_cnt = r_perf[i];
      end
    end
  end
`else
  logic w_unused_perf_sel;
  assign w_unused_perf_sel = ^perf_sel;
  assign perf_cnt          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fu_writeback_arbiter.sv
// ============================================================================
// tb_fu_writeback_arbiter : vector table for grant mapping plus a per-FU
//                           scoreboard for payload order. Revision 1.0
// ============================================================================
`default_nettype none

module tb_fu_writeback_arbiter;
  localparam int NF = 6;
  localparam int NP = 2;
  localparam int DW = 96;
`ifdef WB_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       flush;
    logic       stall;
    logic [5:0] valid;
    logic [5:0] exp_ready;
    logic [1:0] exp_cv;
    logic [2:0] exp_s0;
    logic [2:0] exp_s1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [2:0]  perf_sel;
  logic [15:0] perf_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          seq     = 0;
  logic [DW-1:0] sb [NF][$];
  vec_t        tbl [$];

  fu_writeback_arbiter_if #(.NUM_FU(NF), .NUM_PORTS(NP), .DATA_W(DW)) bus ();

  fu_writeback_arbiter #(
    .NUM_FU(NF), .NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .perf_sel (perf_sel),
    .perf_cnt (perf_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t V(input logic r, input logic f, input logic s,
                             input logic [5:0] v, input logic [5:0] er,
                             input logic [1:0] cv, input logic [2:0] s0,
                             input logic [2:0] s1);
    vec_t t;
    t.rst = r; t.flush = f; t.stall = s; t.valid = v;
    t.exp_ready = er; t.exp_cv = cv; t.exp_s0 = s0; t.exp_s1 = s1;
    return t;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic s,
                       input logic [5:0] v);
    @(posedge clk);
    #1;
    reset            = r;
    flush            = f;
    bus.commit_stall = s;
    bus.fu_valid     = v;
    for (int i = 0; i < NF; i++) begin
      bus.fu_data[i*DW +: DW] = {32'(i), 32'(seq), $urandom()};
    end
    seq++;
  endtask

  task automatic chk_perf(input string nm, input logic [2:0] sel,
                          input logic [15:0] val);
    perf_sel = sel;
    #1;
    chk(nm, int'(sel), 32'(perf_cnt), PERF ? 32'(val) : 32'd0);
  endtask

  // Accepted pushes enter the FU's queue after this cycle's commits are
  // checked, so a same-cycle bypass would show up as a payload error.
  always @(negedge clk) begin
    int            si;
    logic [DW-1:0] exp_d;
    if (reset || flush) begin
      for (int i = 0; i < NF; i++) sb[i].delete();
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (bus.commit_valid[k]) begin
          if (!bus.commit_stall) begin
            si = int'(bus.commit_src[k*3 +: 3]);
            n_tests++;
            if (si >= NF || sb[si].size() == 0) begin
              n_fail++;
              $display("FAIL sb_unexpected port %0d: got src %0d with nothing queued", k, si);
            end else begin
              exp_d = sb[si].pop_front();
              if (bus.commit_data[k*DW +: DW] !== exp_d) begin
                n_fail++;
                $display("FAIL sb_data port %0d src %0d: got %h expected %h",
                         k, si, bus.commit_data[k*DW +: DW], exp_d);
              end
            end
          end
        end else begin
          n_tests++;
          if (bus.commit_data[k*DW +: DW] !== '0) begin
            n_fail++;
            $display("FAIL idle_data port %0d: got %h expected 0",
                     k, bus.commit_data[k*DW +: DW]);
          end
        end
      end
      for (int i = 0; i < NF; i++) begin
        if (bus.fu_valid[i] && bus.fu_ready[i]) sb[i].push_back(bus.fu_data[i*DW +: DW]);
      end
    end
  end

  initial begin
    int total;
    reset = 1'b1; flush = 1'b0; perf_sel = 3'd5;
    bus.commit_stall = 1'b0; bus.fu_valid = '0; bus.fu_data = '0;

    // reset, idle, single FU2 push with one-cycle latency
    tbl.push_back(V(1,0,0,6'h00, 6'h00,2'b00,0,0));
    tbl.push_back(V(1,0,0,6'h00, 6'h00,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h04, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b01,2,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b00,0,0));
    // mid-run reset, then FU1/FU3/FU4 from rr_ptr=0, then wrap from rr_ptr=5
    tbl.push_back(V(1,0,0,6'h00, 6'h00,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h1A, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b11,1,3));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b01,4,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h21, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b11,5,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b00,0,0));
    // FU0 three pushes under stall: ready drops after two, third held
    tbl.push_back(V(0,0,1,6'h01, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,1,6'h01, 6'h3F,2'b01,0,0));
    tbl.push_back(V(0,0,1,6'h01, 6'h3E,2'b01,0,0));
    tbl.push_back(V(0,0,0,6'h01, 6'h3E,2'b01,0,0));
    tbl.push_back(V(0,0,0,6'h01, 6'h3F,2'b01,0,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b01,0,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b00,0,0));
    // flush to rr_ptr=0, fill all FIFOs, drain two per cycle
    tbl.push_back(V(0,1,0,6'h00, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,1,6'h3F, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,1,6'h3F, 6'h3F,2'b11,0,1));
    tbl.push_back(V(0,0,0,6'h00, 6'h00,2'b11,0,1));
    tbl.push_back(V(0,0,0,6'h00, 6'h03,2'b11,2,3));
    tbl.push_back(V(0,0,0,6'h00, 6'h0F,2'b11,4,5));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b11,0,1));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b11,2,3));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b11,4,5));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b00,0,0));
    // flush with FU2 pending, rr_ptr=2 and pushes asserted
    tbl.push_back(V(0,0,0,6'h07, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b11,0,1));
    tbl.push_back(V(0,1,0,6'h38, 6'h3F,2'b01,2,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h22, 6'h3F,2'b00,0,0));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b11,1,5));
    tbl.push_back(V(0,0,0,6'h00, 6'h3F,2'b00,0,0));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].rst, tbl[r].flush, tbl[r].stall, tbl[r].valid);
      @(negedge clk);
      if (!tbl[r].rst) begin
        chk("fu_ready",     r, 32'(bus.fu_ready),          32'(tbl[r].exp_ready));
        chk("commit_valid", r, 32'(bus.commit_valid),      32'(tbl[r].exp_cv));
        chk("src0",         r, 32'(bus.commit_src[2:0]),   32'(tbl[r].exp_s0));
        chk("src1",         r, 32'(bus.commit_src[5:3]),   32'(tbl[r].exp_s1));
      end
    end

    total = 0;
    for (int i = 0; i < NF; i++) total += sb[i].size();
    chk("sb_drain", 0, 32'(total), 32'd0);

    // starvation counters: fill all, one stalled cycle, then {0,1},{2,3},{4,5}
    drive(1, 0, 0, 6'h00);
    drive(0, 0, 0, 6'h00);
    @(negedge clk);
    chk_perf("perf_reset", 3'd5, 16'd0);
    drive(0, 0, 0, 6'h3F);
    drive(0, 0, 1, 6'h00);
    drive(0, 0, 0, 6'h00);
    drive(0, 0, 0, 6'h00);
    drive(0, 0, 0, 6'h00);
    drive(0, 0, 0, 6'h00);
    @(negedge clk);
    chk("perf_drained", 0, 32'(bus.commit_valid), 32'd0);
    chk_perf("perf_fu5", 3'd5, 16'd2);
    chk_perf("perf_fu4", 3'd4, 16'd2);
    chk_perf("perf_fu3", 3'd3, 16'd1);
    chk_perf("perf_fu2", 3'd2, 16'd1);
    chk_perf("perf_fu0", 3'd0, 16'd0);
    chk_perf("perf_sel6", 3'd6, 16'd0);
    chk_perf("perf_sel7", 3'd7, 16'd0);
    drive(0, 1, 0, 6'h00);
    drive(0, 0, 0, 6'h00);
    @(negedge clk);
    chk_perf("perf_after_flush", 3'd5, 16'd2);
    drive(1, 0, 0, 6'h00);
    drive(0, 0, 0, 6'h00);
    @(negedge clk);
    chk_perf("perf_after_reset", 3'd5, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
